// File: rtl/minimips_pkg.sv
// Shared constants for the miniMIPS multi-cycle control unit: opcodes,
// ALU and PC-source encodings, FSM state codes and the decoded instruction class.
package minimips_pkg;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BNE   = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_SLT   = 3'd4;
    localparam logic [2:0] ALU_FUNCT = 3'd5;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_IF   = 3'd1;
    localparam logic [2:0] ST_ID   = 3'd2;
    localparam logic [2:0] ST_EX   = 3'd3;
    localparam logic [2:0] ST_MEM  = 3'd4;
    localparam logic [2:0] ST_WB   = 3'd5;
    localparam logic [2:0] ST_HALT = 3'd6;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

endpackage

// File: rtl/minimips_ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU operation,
// immediate extension mode and register destination select.
module minimips_ctrl_decode
    import minimips_pkg::*;
(
    input  logic [3:0]   opcode,
    output instr_class_e cls,
    output logic [2:0]   alu_op,
    output logic         imm_signed,
    output logic         reg_dst
);

    always_comb begin
        cls        = CLS_ILLEGAL;
        alu_op     = ALU_ADD;
        imm_signed = 1'b0;
        reg_dst    = 1'b0;
        case (opcode)
            OP_RTYPE: begin cls = CLS_ALU;   alu_op = ALU_FUNCT; reg_dst = 1'b1;    end
            OP_ADDI:  begin cls = CLS_ALU;   alu_op = ALU_ADD;   imm_signed = 1'b1; end
            OP_ANDI:  begin cls = CLS_ALU;   alu_op = ALU_AND;   end
            OP_ORI:   begin cls = CLS_ALU;   alu_op = ALU_OR;    end
            OP_SLTI:  begin cls = CLS_ALU;   alu_op = ALU_SLT;   imm_signed = 1'b1; end
            OP_LW:    begin cls = CLS_LOAD;  alu_op = ALU_ADD;   imm_signed = 1'b1; end
            OP_SW:    begin cls = CLS_STORE; alu_op = ALU_ADD;   imm_signed = 1'b1; end
            OP_BEQ:   begin cls = CLS_BEQ;   alu_op = ALU_SUB;   imm_signed = 1'b1; end
            OP_BNE:   begin cls = CLS_BNE;   alu_op = ALU_SUB;   imm_signed = 1'b1; end
            OP_HALT:  begin cls = CLS_HALT;  end
            default:  begin cls = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/minimips_multicycle_ctrl.sv
// Multi-cycle miniMIPS control FSM (IF/ID/EX/MEM/WB) over a shared memory port.
// Define MINIMIPS_CTRL_ILLEGAL_TRAP_EN to trap opcodes 9-14 into HALT via `illegal`.
module minimips_multicycle_ctrl
    import minimips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_load,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_imm,
    output logic [2:0]  alu_op,
    output logic        imm_signed,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        busy,
    output logic        halted,
    output logic        mem_err
`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    logic [2:0]   state_q, next_state;
    logic [3:0]   opcode_q, dec_opcode;
    instr_class_e dec_cls;
    logic [2:0]   dec_alu_op;
    logic         dec_imm_signed, dec_reg_dst;
    logic         in_exec, timeout_hit, mem_err_q;
    logic         unused_instr_bits;

    assign unused_instr_bits = ^instr[11:0];

    // In ID the opcode is still only on the IR bus; afterwards the latched copy drives decode.
    assign dec_opcode = (state_q == ST_ID) ? instr[15:12] : opcode_q;

    minimips_ctrl_decode u_decode (
        .opcode     (dec_opcode),
        .cls        (dec_cls),
        .alu_op     (dec_alu_op),
        .imm_signed (dec_imm_signed),
        .reg_dst    (dec_reg_dst)
    );

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
            logic [CNT_W-1:0] wait_cnt;

            assign timeout_hit = mem_req && !mem_ack && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wait_cnt <= '0;
                end else if (!mem_req || mem_ack || timeout_hit) begin
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        next_state = state_q;
        case (state_q)
            ST_IDLE: if (start) next_state = ST_IF;
            ST_IF:   if (mem_ack) next_state = ST_ID;
            ST_ID: begin
                case (dec_cls)
                    CLS_HALT: next_state = ST_HALT;
`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
                    CLS_ILLEGAL: next_state = ST_HALT;
`else
                    CLS_ILLEGAL: next_state = ST_IF;
`endif
                    default:  next_state = ST_EX;
                endcase
            end
            ST_EX: begin
                case (dec_cls)
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                    CLS_BEQ, CLS_BNE:    next_state = ST_IF;
                    default:             next_state = ST_WB;
                endcase
            end
            ST_MEM:  if (mem_ack) next_state = (dec_cls == CLS_LOAD) ? ST_WB : ST_IF;
            ST_WB:   next_state = ST_IF;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_IDLE;
        endcase
        if (timeout_hit) next_state = ST_HALT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            opcode_q  <= 4'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == ST_ID) opcode_q <= instr[15:12];
            if (timeout_hit) mem_err_q <= 1'b1;
        end
    end

`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == ST_ID && dec_cls == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`endif

    // Extender mode, ALU op and operand select stay stable across EX, MEM and WB.
    assign in_exec = (state_q == ST_EX) || (state_q == ST_MEM) || (state_q == ST_WB);

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_INC;
        alu_src_imm  = 1'b0;
        alu_op       = ALU_ADD;
        imm_signed   = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        if (in_exec) begin
            alu_op      = dec_alu_op;
            imm_signed  = dec_imm_signed;
            alu_src_imm = (dec_cls == CLS_ALU && !dec_reg_dst) ||
                          dec_cls == CLS_LOAD || dec_cls == CLS_STORE;
        end
        case (state_q)
            ST_IF: begin
                mem_req  = 1'b1;
                ir_load  = mem_ack;
                pc_write = mem_ack;
            end
            ST_EX: begin
                if (dec_cls == CLS_BEQ || dec_cls == CLS_BNE) begin
                    pc_src   = PC_SRC_BRANCH;
                    pc_write = (dec_cls == CLS_BEQ) ? alu_zero : !alu_zero;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (dec_cls == CLS_STORE);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = dec_reg_dst;
                mem_to_reg = (dec_cls == CLS_LOAD);
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted  = (state_q == ST_HALT);
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_minimips_multicycle_ctrl.sv
// Directed bench for minimips_multicycle_ctrl: per-instruction cycle traces, waits,
// branches, illegal/halt handling, async reset and the memory timeout.
module tb_minimips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req, mem_we, mem_addr_sel, ir_load, pc_write;
        logic [1:0] pc_src;
        logic       alu_src_imm;
        logic [2:0] alu_op;
        logic       imm_signed, reg_write, reg_dst, mem_to_reg, busy;
    } snap_t;

    localparam int MAXC = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, alu_zero = 1'b0, mem_ack = 1'b0;
    logic [15:0] instr = 16'h0;
    logic mem_req, mem_we, mem_addr_sel, ir_load, pc_write, alu_src_imm, imm_signed;
    logic reg_write, reg_dst, mem_to_reg, busy, halted, mem_err;
    logic [1:0] pc_src;
    logic [2:0] alu_op;

    logic t_start = 1'b0, t_ack = 1'b0;
    logic t_mem_req, t_mem_we, t_mem_addr_sel, t_ir_load, t_pc_write, t_alu_src_imm, t_imm_signed;
    logic t_reg_write, t_reg_dst, t_mem_to_reg, t_busy, t_halted, t_mem_err;
    logic [1:0] t_pc_src;
    logic [2:0] t_alu_op;
`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
    logic illegal, t_illegal;
`endif

    snap_t trace [MAXC];
    int ncyc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minimips_multicycle_ctrl #(.MEM_TIMEOUT(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
        .alu_op(alu_op), .imm_signed(imm_signed), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .busy(busy), .halted(halted), .mem_err(mem_err)
`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    minimips_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset_n(reset_n), .start(t_start), .instr(instr), .alu_zero(alu_zero),
        .mem_ack(t_ack), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr_sel(t_mem_addr_sel),
        .ir_load(t_ir_load), .pc_write(t_pc_write), .pc_src(t_pc_src), .alu_src_imm(t_alu_src_imm),
        .alu_op(t_alu_op), .imm_signed(t_imm_signed), .reg_write(t_reg_write), .reg_dst(t_reg_dst),
        .mem_to_reg(t_mem_to_reg), .busy(t_busy), .halted(t_halted), .mem_err(t_mem_err)
`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
        , .illegal(t_illegal)
`endif
    );

    // Responsive memory: acks a request after the given number of wait cycles.
    // Entered right after a clock edge with the DUT in IF; stops when the next IF begins.
    task automatic run_instr(input logic [15:0] ins, input int wif, input int wmem, input logic az);
        int waited = 0;
        logic prev_if = 1'b0;
        instr = ins;
        alu_zero = az;
        ncyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            if (c > 0 && (halted || !busy || (mem_req && !mem_addr_sel && !prev_if))) break;
            if (mem_req) begin
                if (waited == (mem_addr_sel ? wmem : wif)) begin
                    mem_ack = 1'b1;
                    waited = 0;
                end else begin
                    mem_ack = 1'b0;
                    waited++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
            trace[c] = '{mem_req, mem_we, mem_addr_sel, ir_load, pc_write, pc_src, alu_src_imm,
                         alu_op, imm_signed, reg_write, reg_dst, mem_to_reg, busy};
            prev_if = mem_req && !mem_addr_sel;
            ncyc = c + 1;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        start = 1'b0;
        t_start = 1'b0;
        mem_ack = 1'b0;
        #3;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++; if ({mem_req, ir_load, pc_write, reg_write, busy, halted, mem_err} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 0000000",
                               {mem_req, ir_load, pc_write, reg_write, busy, halted, mem_err}); end
        checks++; if ({pc_src, alu_op, imm_signed, alu_src_imm} !== 7'b0) begin
            errors++; $display("FAIL reset_datapath_sel: got %b expected 0000000",
                               {pc_src, alu_op, imm_signed, alu_src_imm}); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL idle_without_start: got busy=%b mem_req=%b expected 0 0", busy, mem_req); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi();
        do_start();
        run_instr(16'h1085, 0, 0, 1'b0);
        checks++; if (ncyc !== 4) begin errors++; $display("FAIL addi_cycles: got %0d expected 4", ncyc); end
        checks++; if ({trace[0].mem_req, trace[0].mem_addr_sel, trace[0].ir_load, trace[0].pc_write, trace[0].pc_src} !== 6'b101100) begin
            errors++; $display("FAIL addi_if: got %b expected 101100",
                {trace[0].mem_req, trace[0].mem_addr_sel, trace[0].ir_load, trace[0].pc_write, trace[0].pc_src}); end
        checks++; if (trace[1].mem_req !== 1'b0 || trace[1].reg_write !== 1'b0) begin
            errors++; $display("FAIL addi_id_quiet: got req=%b rw=%b expected 0 0", trace[1].mem_req, trace[1].reg_write); end
        checks++; if ({trace[2].imm_signed, trace[2].alu_src_imm, trace[2].alu_op, trace[2].reg_write} !== 6'b110000) begin
            errors++; $display("FAIL addi_ex: got %b expected 110000",
                {trace[2].imm_signed, trace[2].alu_src_imm, trace[2].alu_op, trace[2].reg_write}); end
        checks++; if ({trace[3].reg_write, trace[3].reg_dst, trace[3].mem_to_reg, trace[3].imm_signed} !== 4'b1001) begin
            errors++; $display("FAIL addi_wb: got %b expected 1001",
                {trace[3].reg_write, trace[3].reg_dst, trace[3].mem_to_reg, trace[3].imm_signed}); end
    endtask

    task automatic test_alu_ops();
        run_instr(16'h2ABF, 0, 0, 1'b0);
        checks++; if ({trace[2].imm_signed, trace[2].alu_op, trace[2].alu_src_imm} !== 5'b00101 || ncyc !== 4) begin
            errors++; $display("FAIL andi_ex: got %b cycles %0d expected 00101 cycles 4",
                {trace[2].imm_signed, trace[2].alu_op, trace[2].alu_src_imm}, ncyc); end
        run_instr(16'h3283, 0, 0, 1'b0);
        checks++; if (trace[2].alu_op !== 3'd3 || trace[3].imm_signed !== 1'b0) begin
            errors++; $display("FAIL ori_ex: got op=%0d sgn=%b expected 3 0", trace[2].alu_op, trace[3].imm_signed); end
        run_instr(16'h4283, 0, 0, 1'b0);
        checks++; if (trace[2].alu_op !== 3'd4 || trace[2].imm_signed !== 1'b1) begin
            errors++; $display("FAIL slti_ex: got op=%0d sgn=%b expected 4 1", trace[2].alu_op, trace[2].imm_signed); end
        run_instr(16'h0291, 0, 0, 1'b0);
        checks++; if ({trace[2].alu_op, trace[2].alu_src_imm, trace[3].reg_write, trace[3].reg_dst} !== 6'b101011 || ncyc !== 4) begin
            errors++; $display("FAIL rtype: got %b cycles %0d expected 101011 cycles 4",
                {trace[2].alu_op, trace[2].alu_src_imm, trace[3].reg_write, trace[3].reg_dst}, ncyc); end
    endtask

    task automatic test_fetch_wait();
        run_instr(16'h1085, 2, 0, 1'b0);
        checks++; if (ncyc !== 6) begin errors++; $display("FAIL if_wait_cycles: got %0d expected 6", ncyc); end
        checks++; if (trace[0].ir_load !== 1'b0 || trace[1].mem_req !== 1'b1 || trace[2].ir_load !== 1'b1) begin
            errors++; $display("FAIL if_wait_hold: got ld0=%b req1=%b ld2=%b expected 0 1 1",
                trace[0].ir_load, trace[1].mem_req, trace[2].ir_load); end
    endtask

    task automatic test_load_store();
        int mem_cycles = 0;
        run_instr(16'h5283, 0, 3, 1'b0);
        for (int i = 0; i < ncyc; i++) if (trace[i].mem_req && trace[i].mem_addr_sel && !trace[i].mem_we) mem_cycles++;
        checks++; if (ncyc !== 8) begin errors++; $display("FAIL lw_cycles: got %0d expected 8", ncyc); end
        checks++; if (mem_cycles !== 4) begin errors++; $display("FAIL lw_mem_hold: got %0d expected 4", mem_cycles); end
        checks++; if ({trace[7].reg_write, trace[7].mem_to_reg, trace[7].reg_dst, trace[7].alu_src_imm} !== 4'b1101) begin
            errors++; $display("FAIL lw_wb: got %b expected 1101",
                {trace[7].reg_write, trace[7].mem_to_reg, trace[7].reg_dst, trace[7].alu_src_imm}); end
        run_instr(16'h6283, 0, 0, 1'b0);
        checks++; if (ncyc !== 4 || {trace[3].mem_req, trace[3].mem_addr_sel, trace[3].mem_we, trace[3].reg_write} !== 4'b1110) begin
            errors++; $display("FAIL sw: got %b cycles %0d expected 1110 cycles 4",
                {trace[3].mem_req, trace[3].mem_addr_sel, trace[3].mem_we, trace[3].reg_write}, ncyc); end
    endtask

    task automatic test_branches();
        run_instr(16'h7283, 0, 0, 1'b1);
        checks++; if (ncyc !== 3 || {trace[2].pc_write, trace[2].pc_src, trace[2].alu_op} !== 6'b101001) begin
            errors++; $display("FAIL beq_taken: got %b cycles %0d expected 101001 cycles 3",
                {trace[2].pc_write, trace[2].pc_src, trace[2].alu_op}, ncyc); end
        run_instr(16'h7283, 0, 0, 1'b0);
        checks++; if (ncyc !== 3 || trace[2].pc_write !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken: got pc_write=%b cycles %0d expected 0 cycles 3", trace[2].pc_write, ncyc); end
        run_instr(16'h8283, 0, 0, 1'b0);
        checks++; if (trace[2].pc_write !== 1'b1 || trace[2].pc_src !== 2'd1) begin
            errors++; $display("FAIL bne_taken: got pc_write=%b pc_src=%0d expected 1 1", trace[2].pc_write, trace[2].pc_src); end
        run_instr(16'h8283, 0, 0, 1'b1);
        checks++; if (trace[2].pc_write !== 1'b0) begin
            errors++; $display("FAIL bne_not_taken: got pc_write=%b expected 0", trace[2].pc_write); end
    endtask

    task automatic test_illegal();
        run_instr(16'hA283, 0, 0, 1'b0);
        checks++; if (ncyc !== 2 || trace[1].reg_write !== 1'b0 || trace[1].pc_write !== 1'b0) begin
            errors++; $display("FAIL illegal_id: got cycles %0d rw=%b pw=%b expected 2 0 0", ncyc, trace[1].reg_write, trace[1].pc_write); end
`ifdef MINIMIPS_CTRL_ILLEGAL_TRAP_EN
        checks++; if (illegal !== 1'b1 || halted !== 1'b1) begin
            errors++; $display("FAIL illegal_trap: got illegal=%b halted=%b expected 1 1", illegal, halted); end
`else
        checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr_sel !== 1'b0) begin
            errors++; $display("FAIL illegal_nop: got halted=%b req=%b sel=%b expected 0 1 0", halted, mem_req, mem_addr_sel); end
`endif
        do_reset();
        do_start();
    endtask

    task automatic test_halt();
        run_instr(16'hF000, 0, 0, 1'b0);
        checks++; if (ncyc !== 2 || halted !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL halt_enter: got cycles %0d halted=%b busy=%b expected 2 1 0", ncyc, halted, busy); end
        start = 1'b1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || ir_load !== 1'b0 || pc_write !== 1'b0) begin
            errors++; $display("FAIL halt_absorbing: got halted=%b req=%b ld=%b pw=%b expected 1 0 0 0",
                halted, mem_req, ir_load, pc_write); end
        start = 1'b0;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        do_start();
        instr = 16'h5283;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr_sel !== 1'b1) begin
            errors++; $display("FAIL mem_wait_before_reset: got req=%b sel=%b expected 1 1", mem_req, mem_addr_sel); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || mem_addr_sel !== 1'b0) begin
            errors++; $display("FAIL async_reset_drop: got req=%b busy=%b sel=%b expected 0 0 0", mem_req, busy, mem_addr_sel); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        instr = 16'h1085;
        t_start = 1'b1;
        @(posedge clk);
        #1;
        t_start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++; if (t_mem_req !== 1'b1 || t_mem_err !== 1'b0 || t_halted !== 1'b0) begin
            errors++; $display("FAIL timeout_pending: got req=%b err=%b halted=%b expected 1 0 0", t_mem_req, t_mem_err, t_halted); end
        @(posedge clk);
        #1;
        checks++; if (t_mem_err !== 1'b1 || t_halted !== 1'b1 || t_mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_fire: got err=%b halted=%b req=%b expected 1 1 0", t_mem_err, t_halted, t_mem_req); end
        checks++; if (mem_err !== 1'b0) begin
            errors++; $display("FAIL no_timeout_default: got mem_err=%b expected 0", mem_err); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_ops();
        test_fetch_wait();
        test_load_store();
        test_branches();
        test_illegal();
        test_halt();
        test_reset_mid_mem();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
